// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit.
// Steps each instruction through fetch, decode, execute, memory and writeback
// states, and drives the datapath strobes for the current state.
module mips_mc_ctrl #(
  parameter logic [3:0]  RESET_STATE = 4'd0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [3:0]       ALUcontrol,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic             pc_en,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StRtEx   = 4'd6;
  localparam logic [3:0] StRtWb   = 4'd7;
  localparam logic [3:0] StBeq    = 4'd8;
  localparam logic [3:0] StAddiEx = 4'd9;
  localparam logic [3:0] StAddiWb = 4'd10;
  localparam logic [3:0] StJmp    = 4'd11;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  logic [3:0] state_d;
  logic       dec_illegal;
  logic       retire;
  logic [3:0] rt_alu;
  logic       rt_ok;
  logic       pc_write;

  // R-type funct decode, shared by next-state and ALU control.
  always_comb begin
    rt_ok  = 1'b1;
    rt_alu = AluAnd;
    case (funct)
      6'b100000: rt_alu = AluAdd;
      6'b100010: rt_alu = AluSub;
      6'b100100: rt_alu = AluAnd;
      6'b100101: rt_alu = AluOr;
      6'b101010: rt_alu = AluSlt;
      default:   rt_ok  = 1'b0;
    endcase
  end

  // Next-state selection and illegal-instruction detection.
  always_comb begin
    state_d     = StFetch;
    dec_illegal = 1'b0;
    retire      = 1'b0;
    case (state)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRtype:    state_d = StRtEx;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBeq;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJmp;
          default:    dec_illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        // Opcode is re-sampled here; anything but lw/sw is treated as illegal.
        if (opcode == OpLw)      state_d = StMemRd;
        else if (opcode == OpSw) state_d = StMemWr;
        else                     dec_illegal = 1'b1;
      end
      StMemRd:  state_d = StMemWb;
      StRtEx: begin
        if (rt_ok) state_d = StRtWb;
        else       dec_illegal = 1'b1;
      end
      StAddiEx: state_d = StAddiWb;
      StMemWb, StMemWr, StRtWb, StBeq, StAddiWb, StJmp: retire = 1'b1;
      default:  dec_illegal = 1'b1;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_STATE;
      retired <= '0;
    end else begin
      state <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Moore strobes per state; reset masks every enable and the ALU op.
  always_comb begin
    ALUcontrol = AluAnd;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    pc_write   = 1'b0;
    case (state)
      StFetch: begin
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUcontrol = AluAdd;
        pc_write   = 1'b1;
      end
      StDecode: begin
        ALUSrcB    = 2'b11;
        ALUcontrol = AluAdd;
      end
      StMemAdr, StAddiEx: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUcontrol = AluAdd;
      end
      StMemRd:  IorD = 1'b1;
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StRtEx: begin
        ALUSrcA    = 1'b1;
        ALUcontrol = rt_alu;
      end
      StRtWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBeq: begin
        ALUSrcA    = 1'b1;
        ALUcontrol = AluSub;
        Branch     = 1'b1;
        PCSrc      = 2'b01;
      end
      StAddiWb: RegWrite = 1'b1;
      StJmp: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    illegal = dec_illegal;
    pc_en   = pc_write | (Branch & zero);
    if (rst) begin
      ALUcontrol = AluAnd;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      Branch     = 1'b0;
      illegal    = 1'b0;
      pc_en      = 1'b0;
    end
  end

endmodule
